alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one instance of the team's 8-bit `alu` between NREQ requesters.
- Each requester issues an operation (a, b, ctrl) over a valid/ready handshake.
- The arbiter latches the granted operands, runs one ALU pass, and returns y plus the flags on a single tagged response channel with backpressure.
- It sits between the command-issuing units and the shared ALU datapath.

Parameters:
- NREQ, 2, number of requesters (2..8).
- IDW, 3, width of the response requester ID; must satisfy 2**IDW >= NREQ.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  NREQ  bit i: requester i presents a command.
- req_ready  out  NREQ  bit i: command i accepted this cycle (one-hot or zero).
- req_a  in  8*NREQ  operand a, requester i at [8i+7:8i].
- req_b  in  8*NREQ  operand b, same packing.
- req_ctrl  in  3*NREQ  ALU opcode, requester i at [3i+2:3i].
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts the response.
- rsp_id  out  IDW  index of the requester that owns the response.
- rsp_y  out  8  result.
- rsp_negative, rsp_carry, rsp_zero  out  1 each  ALU flags.
- rsp_err  out  1  opcode is not one of AND/OR/ADD/SUB.

Behaviour:
- Opcodes:
  - 000 AND, 001 OR, 010 ADD, 110 SUB.
  - All other codes are illegal.
- Flag rules (produced by the ALU, passed through unchanged):
  - zero = (y==0) for all four legal ops.
  - carry = bit 8 of the 9-bit sum for ADD, or of the 9-bit difference (borrow) for SUB; 0 for AND/OR.
  - negative = (a<b unsigned) for SUB only; 0 otherwise.
  - Illegal op: all three flags 0, rsp_y forced to 8'h00, rsp_err=1.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any req_valid is high, grant the first set bit searching upward from (last_grant+1) mod NREQ.
  - Raise req_ready[g] combinationally in this cycle only; this handshake is the accept.
  - Latch a, b, ctrl and g; update last_grant=g; go to EXEC.
  - If no valid, stay in IDLE; req_ready=0.
- EXEC (1 cycle): the latched operands drive the ALU. At the clock edge, capture y and the flags into the response registers (forcing y/flags as above for illegal ops) and set rsp_valid=1. Go to RESP.
- RESP:
  - Hold rsp_* stable while rsp_valid=1 and rsp_ready=0.
  - On rsp_valid&rsp_ready, clear rsp_valid and go to IDLE.
  - No new accept occurs in RESP.
- Latency: accept at cycle T gives rsp_valid=1 from cycle T+2. Minimum issue interval is 3 cycles.
- Fairness: a requester holding valid is granted within NREQ accepts.
- req_ready is never high outside IDLE.
- Requester inputs are don't-care except in the accept cycle; a requester may change or drop its command before it is accepted.
- Reset (async, any state, including mid-EXEC or mid-RESP):
  - state=IDLE, rsp_valid=0, req_ready=0.
  - rsp_y=0, rsp_id=0, all flags and rsp_err=0.
  - last_grant=NREQ-1, so requester 0 has first priority.
  - Any in-flight command is discarded.
- Arithmetic is 8-bit with wrap-around; e.g. 200+100 gives y=44, carry=1.

Decomposition:
- Package alu_pkg:
  - opcode localparams OP_AND=3'b000, OP_OR=3'b001, OP_ADD=3'b010, OP_SUB=3'b110.
  - an is_legal_op function.
  - FSM state encoding IDLE/EXEC/RESP.
- Sub-module: instantiate the existing `alu` (a, b, ctrl, y, negative, carry, zero) unmodified.
- Round-robin grant logic may be a small function in the package.

Test Plan:
- Reset then req_valid=01, a=8'd200, b=8'd100, ctrl=010:
  - req_ready[0]=1 in the first cycle.
  - Two cycles later rsp_valid=1, rsp_id=0, y=44, carry=1, zero=0, negative=0, err=0.
- Requester 1 SUB, a=5, b=9, with rsp_ready held 0 for 4 cycles → response stays stable: y=252, carry=1, negative=1, zero=0, id=1. It is released on the cycle rsp_ready=1.
- Both requesters valid continuously for 6 commands → grant order 0,1,0,1,0,1. req_ready is never high for both requesters at once.
- AND a=8'hF0, b=8'h0F → y=0, zero=1, carry=0, negative=0. SUB a=77, b=77 → y=0, zero=1, carry=0, negative=0.
- ctrl=011 and ctrl=111 → y=0, negative=carry=zero=0, err=1.
- Assert rst_n=0 asynchronously during EXEC, then deassert → rsp_valid=0 immediately. The next grant with both requesters valid goes to requester 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its round-robin arbiter: opcodes,
// sequencer states and the grant-selection helper.
package alu_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic is_legal_op(input logic [2:0] op);
    return (op == OP_AND) || (op == OP_OR) || (op == OP_ADD) || (op == OP_SUB);
  endfunction

  // First set bit of valid, searching upward from last+1 and wrapping at nreq.
  function automatic logic [2:0] rr_pick(input logic [7:0] valid,
                                         input logic [2:0] last,
                                         input int         nreq);
    logic [2:0] pick;
    logic       found;
    int         idx;
    pick  = '0;
    found = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      if (i <= nreq) begin
        idx = (int'(last) + i) % nreq;
        if (!found && valid[idx[2:0]]) begin
          pick  = idx[2:0];
          found = 1'b1;
        end
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/alu.sv
// Shared 8-bit ALU: AND/OR/ADD/SUB with negative/carry/zero flags.
module alu
  import alu_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [2:0] ctrl,
  output logic [7:0] y,
  output logic       negative,
  output logic       carry,
  output logic       zero
);

  logic [8:0] wide;

  always_comb begin
    wide     = '0;
    y        = '0;
    negative = 1'b0;
    carry    = 1'b0;
    zero     = 1'b0;
    case (ctrl)
      OP_AND: begin
        y    = a & b;
        zero = (y == 8'h00);
      end
      OP_OR: begin
        y    = a | b;
        zero = (y == 8'h00);
      end
      OP_ADD: begin
        wide  = {1'b0, a} + {1'b0, b};
        y     = wide[7:0];
        carry = wide[8];
        zero  = (y == 8'h00);
      end
      OP_SUB: begin
        // Bit 8 of the 9-bit difference is the borrow.
        wide     = {1'b0, a} - {1'b0, b};
        y        = wide[7:0];
        carry    = wide[8];
        negative = (a < b);
        zero     = (y == 8'h00);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one ALU between NREQ requesters and
// returns each result on a tagged, backpressured response channel.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDW  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [8*NREQ-1:0] req_a,
  input  logic [8*NREQ-1:0] req_b,
  input  logic [3*NREQ-1:0] req_ctrl,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [7:0]        rsp_y,
  output logic              rsp_negative,
  output logic              rsp_carry,
  output logic              rsp_zero,
  output logic              rsp_err
);

  state_t     state;
  logic [2:0] last_grant;
  logic [2:0] grant;
  logic [2:0] id_q;
  logic [7:0] a_q, b_q;
  logic [2:0] ctrl_q;
  logic [7:0] alu_y;
  logic       alu_negative, alu_carry, alu_zero;

  assign grant = rr_pick(8'(req_valid), last_grant, NREQ);

  // The accept handshake is combinational and only ever offered in IDLE.
  always_comb begin
    req_ready = '0;
    if (state == IDLE && |req_valid)
      req_ready = NREQ'(1) << grant;
  end

  alu u_alu (
    .a        (a_q),
    .b        (b_q),
    .ctrl     (ctrl_q),
    .y        (alu_y),
    .negative (alu_negative),
    .carry    (alu_carry),
    .zero     (alu_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      last_grant   <= 3'(NREQ - 1);
      id_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      ctrl_q       <= '0;
      rsp_valid    <= 1'b0;
      rsp_id       <= '0;
      rsp_y        <= '0;
      rsp_negative <= 1'b0;
      rsp_carry    <= 1'b0;
      rsp_zero     <= 1'b0;
      rsp_err      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|req_valid) begin
            a_q        <= req_a[8*grant +: 8];
            b_q        <= req_b[8*grant +: 8];
            ctrl_q     <= req_ctrl[3*grant +: 3];
            id_q       <= grant;
            last_grant <= grant;
            state      <= EXEC;
          end
        end
        EXEC: begin
          // Illegal opcodes report an error with a zeroed result and flags.
          if (is_legal_op(ctrl_q)) begin
            rsp_y        <= alu_y;
            rsp_negative <= alu_negative;
            rsp_carry    <= alu_carry;
            rsp_zero     <= alu_zero;
            rsp_err      <= 1'b0;
          end else begin
            rsp_y        <= '0;
            rsp_negative <= 1'b0;
            rsp_carry    <= 1'b0;
            rsp_zero     <= 1'b0;
            rsp_err      <= 1'b1;
          end
          rsp_id    <= IDW'(id_q);
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed scoreboard bench for alu_arbiter with two requesters.
module tb_alu_arbiter;

  localparam int NREQ = 2;
  localparam int IDW  = 3;

  logic              clk;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [8*NREQ-1:0] req_a;
  logic [8*NREQ-1:0] req_b;
  logic [3*NREQ-1:0] req_ctrl;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [7:0]        rsp_y;
  logic              rsp_negative, rsp_carry, rsp_zero, rsp_err;

  typedef struct {
    logic [2:0] id;
    logic [7:0] y;
    logic       n;
    logic       c;
    logic       z;
    logic       e;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  alu_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_ctrl     (req_ctrl),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_y        (rsp_y),
    .rsp_negative (rsp_negative),
    .rsp_carry    (rsp_carry),
    .rsp_zero     (rsp_zero),
    .rsp_err      (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference behaviour written from the opcode table, independent of the RTL.
  function automatic exp_t model(input logic [2:0] id, input logic [7:0] a,
                                 input logic [7:0] b, input logic [2:0] op);
    exp_t r;
    int   s;
    r.id = id; r.y = 8'h00; r.n = 1'b0; r.c = 1'b0; r.z = 1'b0; r.e = 1'b0;
    case (op)
      3'b000: r.y = a & b;
      3'b001: r.y = a | b;
      3'b010: begin s = int'(a) + int'(b); r.y = s[7:0]; r.c = (s > 255); end
      3'b110: begin s = int'(a) - int'(b); r.y = s[7:0]; r.c = (a < b); r.n = (a < b); end
      default: r.e = 1'b1;
    endcase
    if (!r.e) r.z = (r.y == 8'h00);
    return r;
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input int i, input logic [7:0] a, input logic [7:0] b,
                                input logic [2:0] op);
    req_a[8*i +: 8]    = a;
    req_b[8*i +: 8]    = b;
    req_ctrl[3*i +: 3] = op;
  endtask

  // Waits (bounded) for an offered grant, checks who got it, records the expectation.
  task automatic accept(input int exp_g);
    int n = 0;
    #1;
    while (req_ready == '0 && n < 20) begin
      @(negedge clk); #1; n++;
    end
    check_output("grant", 32'(req_ready), 32'(2'b01 << exp_g));
    sb.push_back(model(3'(exp_g), req_a[8*exp_g +: 8], req_b[8*exp_g +: 8],
                       req_ctrl[3*exp_g +: 3]));
    @(negedge clk);
    check_output("exec_no_rsp", 32'(rsp_valid), 32'd0);
    check_output("exec_no_ready", 32'(req_ready), 32'd0);
  endtask

  task automatic compare_rsp(input string tag, input exp_t e);
    check_output({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    check_output({tag, "_id"}, 32'(rsp_id), 32'(e.id));
    check_output({tag, "_y"}, 32'(rsp_y), 32'(e.y));
    check_output({tag, "_neg"}, 32'(rsp_negative), 32'(e.n));
    check_output({tag, "_carry"}, 32'(rsp_carry), 32'(e.c));
    check_output({tag, "_zero"}, 32'(rsp_zero), 32'(e.z));
    check_output({tag, "_err"}, 32'(rsp_err), 32'(e.e));
  endtask

  // Response must appear exactly two cycles after accept, then hold under backpressure.
  task automatic collect(input int hold);
    exp_t e;
    @(negedge clk);
    if (sb.size() == 0) begin
      check_output("sb_empty", 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    compare_rsp("rsp", e);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      compare_rsp("hold", e);
      check_output("hold_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check_output("released", 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_ctrl  = '0;
    rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_output("rst_valid", 32'(rsp_valid), 32'd0);
    check_output("rst_ready", 32'(req_ready), 32'd0);
    check_output("rst_y", 32'(rsp_y), 32'd0);
    check_output("rst_id", 32'(rsp_id), 32'd0);
    check_output("rst_flags", {28'd0, rsp_negative, rsp_carry, rsp_zero, rsp_err}, 32'd0);
    rst_n = 1'b1;

    // 200+100 wraps to 44 with carry
    apply_stimulus(0, 8'd200, 8'd100, 3'b010);
    req_valid = 2'b01;
    accept(0);
    req_valid = 2'b00;
    collect(0);

    // SUB 5-9 held under backpressure
    apply_stimulus(1, 8'd5, 8'd9, 3'b110);
    req_valid = 2'b10;
    accept(1);
    req_valid = 2'b00;
    collect(4);

    // Both requesters valid continuously: alternating grants
    req_valid = 2'b11;
    for (int i = 0; i < 6; i++) begin
      apply_stimulus(0, 8'(17 * i + 3), 8'(40 + i), (i % 3 == 0) ? 3'b001 : 3'b010);
      apply_stimulus(1, 8'(30 + i), 8'(7 * i), 3'b110);
      accept(i % 2);
      collect(0);
    end
    req_valid = 2'b00;

    // Zero-result cases
    apply_stimulus(0, 8'hF0, 8'h0F, 3'b000);
    req_valid = 2'b01;
    accept(0);
    req_valid = 2'b00;
    collect(0);
    apply_stimulus(1, 8'd77, 8'd77, 3'b110);
    req_valid = 2'b10;
    accept(1);
    req_valid = 2'b00;
    collect(0);

    // Illegal opcodes
    apply_stimulus(0, 8'hAA, 8'h55, 3'b011);
    req_valid = 2'b01;
    accept(0);
    req_valid = 2'b00;
    collect(1);
    apply_stimulus(1, 8'hFF, 8'h01, 3'b111);
    req_valid = 2'b10;
    accept(1);
    req_valid = 2'b00;
    collect(0);

    // Asynchronous reset mid-EXEC discards the command and restores priority to 0
    apply_stimulus(0, 8'd1, 8'd2, 3'b010);
    req_valid = 2'b01;
    accept(0);
    req_valid = 2'b00;
    void'(sb.pop_back());
    #2 rst_n = 1'b0;
    #1;
    check_output("async_valid", 32'(rsp_valid), 32'd0);
    check_output("async_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    apply_stimulus(0, 8'd9, 8'd4, 3'b110);
    apply_stimulus(1, 8'd3, 8'd3, 3'b010);
    req_valid = 2'b11;
    accept(0);
    req_valid = 2'b00;
    collect(0);

    check_output("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
